// File: rtl/alu_pkg.sv
// Shared op-code encodings, FSM state type and helpers for pipelined_alu.
// The 4-bit op encoding is the same as the original combinational ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: every non-multiply op plus zero/carry/overflow/illegal.
// Multiply codes only report illegal here; the top level runs the real multiplier.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [3:0]       i_control,
    output logic [WIDTH-1:0] o_rd,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;

    assign w_sum   = {1'b0, i_rs1} + {1'b0, i_rs2};
    assign w_diff  = {1'b0, i_rs1} - {1'b0, i_rs2};
    assign w_shamt = i_rs2[SHW-1:0];

    always_comb begin
        o_rd       = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_control)
            OP_AND:  o_rd = i_rs1 & i_rs2;
            OP_OR:   o_rd = i_rs1 | i_rs2;
            OP_XOR:  o_rd = i_rs1 ^ i_rs2;
            OP_ADD: begin
                o_rd       = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_rs1[WIDTH-1] == i_rs2[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_rs1[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (rs1 <u rs2).
                o_rd       = w_diff[WIDTH-1:0];
                o_carry    = w_diff[WIDTH];
                o_overflow = (i_rs1[WIDTH-1] != i_rs2[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_rs1[WIDTH-1]);
            end
            OP_SLL:  o_rd = i_rs1 << w_shamt;
            OP_SRL:  o_rd = i_rs1 >> w_shamt;
            OP_SRA:  o_rd = $signed(i_rs1) >>> w_shamt;
            OP_SLT:  o_rd = {{(WIDTH-1){1'b0}}, ($signed(i_rs1) < $signed(i_rs2))};
            OP_SLTU: o_rd = {{(WIDTH-1){1'b0}}, (i_rs1 < i_rs2)};
            OP_MUL, OP_MULHU: o_illegal = !MUL_EN;
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_zero = (o_rd == '0);

endmodule

// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; results and flags are held until the consumer takes them.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);

    state_t r_state;
    state_t w_next_state;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_last;

    logic [WIDTH-1:0] w_c_rd;
    logic             w_c_zero;
    logic             w_c_carry;
    logic             w_c_overflow;
    logic             w_c_illegal;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHW:0]       r_cnt;
    logic               r_hi;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_step_sum;
    logic [WIDTH-1:0]   w_mul_rd;

    logic [WIDTH-1:0] r_rd;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_illegal;

    alu_comb #(
        .WIDTH  (WIDTH),
        .MUL_EN (MUL_EN)
    ) u_alu_comb (
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .i_control  (control),
        .o_rd       (w_c_rd),
        .o_zero     (w_c_zero),
        .o_carry    (w_c_carry),
        .o_overflow (w_c_overflow),
        .o_illegal  (w_c_illegal)
    );

    assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid  = (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = MUL_EN && is_mul_op(control);
    assign w_mul_last = (r_cnt == MUL_STEPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = w_is_mul ? MUL : DONE;
            MUL:  if (w_mul_last) w_next_state = DONE;
            DONE: begin
                if (w_accept)       w_next_state = w_is_mul ? MUL : DONE;
                else if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The multiplier rides in the low half of the accumulator and is shifted
    // out one bit per step while partial sums enter from the top.
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_step_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_rd   = r_hi ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_hi       <= 1'b0;
            r_rd       <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand <= rs1;
                r_acc   <= {{WIDTH{1'b0}}, rs2};
                r_cnt   <= '0;
                r_hi    <= (control == OP_MULHU);
            end else begin
                r_rd       <= w_c_rd;
                r_zero     <= w_c_zero;
                r_carry    <= w_c_carry;
                r_overflow <= w_c_overflow;
                r_illegal  <= w_c_illegal;
            end
        end else if (r_state == MUL) begin
            if (w_mul_last) begin
                r_rd       <= w_mul_rd;
                r_zero     <= (w_mul_rd == '0);
                r_carry    <= |r_acc[2*WIDTH-1:WIDTH];
                r_overflow <= 1'b0;
                r_illegal  <= 1'b0;
            end else begin
                r_acc <= {w_step_sum, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rd       = r_rd;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: 64-bit single-cycle op table, back-to-back
// and stall sequences, 8-bit multiplier latency/results, MUL_EN=0 and mid-MUL reset.
module tb_pipelined_alu;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
    localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SRA = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1000, C_SLTU = 4'b1001, C_MUL = 4'b1010, C_MULHU = 4'b1011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst64_n, rst8_n;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] rs1_64, rs2_64, rd64;
    logic [3:0]  ctl64;
    logic        zero64, carry64, ovf64, ill64;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  rs1_8, rs2_8, rd8;
    logic [3:0]  ctl8;
    logic        zero8, carry8, ovf8, ill8;

    logic        in_valid8n, in_ready8n, out_valid8n, out_ready8n;
    logic [7:0]  rs1_8n, rs2_8n, rd8n;
    logic [3:0]  ctl8n;
    logic        zero8n, carry8n, ovf8n, ill8n;

    pipelined_alu #(.WIDTH(64), .MUL_EN(1'b1)) dut64 (
        .clk(clk), .rst_n(rst64_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .rs1(rs1_64), .rs2(rs2_64), .control(ctl64), .out_valid(out_valid64),
        .out_ready(out_ready64), .rd(rd64), .zero(zero64), .carry(carry64),
        .overflow(ovf64), .illegal(ill64)
    );

    pipelined_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .rs1(rs1_8), .rs2(rs2_8), .control(ctl8), .out_valid(out_valid8),
        .out_ready(out_ready8), .rd(rd8), .zero(zero8), .carry(carry8),
        .overflow(ovf8), .illegal(ill8)
    );

    pipelined_alu #(.WIDTH(8), .MUL_EN(1'b0)) dut8n (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8n), .in_ready(in_ready8n),
        .rs1(rs1_8n), .rs2(rs2_8n), .control(ctl8n), .out_valid(out_valid8n),
        .out_ready(out_ready8n), .rd(rd8n), .zero(zero8n), .carry(carry8n),
        .overflow(ovf8n), .illegal(ill8n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] rd;
        logic        z;
        logic        c;
        logic        v;
        logic        ill;
    } vec_t;

    vec_t vecs[18];

    task automatic mul8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_rd, input logic exp_c);
        int lat;
        int bad_ready;
        @(negedge clk);
        in_valid8 = 1'b1; ctl8 = op; rs1_8 = a; rs2_8 = b; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        bad_ready = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            if (in_ready8) bad_ready++;
            @(posedge clk); #1;
            if (out_valid8) lat = i;
        end
        check($sformatf("mul%b %h*%h latency", op, a, b), 64'(lat), 64'd9);
        check($sformatf("mul%b in_ready low", op), 64'(bad_ready), 64'd0);
        check($sformatf("mul%b %h*%h rd", op, a, b), 64'(rd8), 64'(exp_rd));
        check($sformatf("mul%b carry", op), 64'(carry8), 64'(exp_c));
        check($sformatf("mul%b zero", op), 64'(zero8), 64'(exp_rd == 8'h00));
        check($sformatf("mul%b overflow", op), 64'(ovf8), 64'd0);
        check($sformatf("mul%b illegal", op), 64'(ill8), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;

        vecs[0]  = '{C_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{C_SUB,  64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{C_SUB,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{C_SRA,  64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{C_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{C_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{C_AND,  64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'h0F00_0F00_0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{C_OR,   64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{C_XOR,  64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{C_SLL,  64'd1, 64'hFFFF_FFFF_FFFF_FF3F, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{C_SRL,  64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{C_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{C_SUB,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{C_ADD,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{4'b1111, 64'h1234, 64'h5678, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{4'b1100, 64'h1234, 64'h5678, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{C_SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{C_SRA,  64'h4000_0000_0000_0000, 64'h3E, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst64_n = 1'b0; rst8_n = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; rs1_64 = '0; rs2_64 = '0; ctl64 = '0;
        in_valid8  = 1'b0; out_ready8  = 1'b0; rs1_8  = '0; rs2_8  = '0; ctl8  = '0;
        in_valid8n = 1'b0; out_ready8n = 1'b0; rs1_8n = '0; rs2_8n = '0; ctl8n = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid64", 64'(out_valid64), 64'd0);
        check("reset rd64", rd64, 64'd0);
        check("reset flags64", {60'd0, zero64, carry64, ovf64, ill64}, 64'd0);
        check("reset out_valid8", 64'(out_valid8), 64'd0);
        check("reset rd8", 64'(rd8), 64'd0);
        check("reset flags8", {60'd0, zero8, carry8, ovf8, ill8}, 64'd0);
        @(negedge clk);
        rst64_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready64 after reset", 64'(in_ready64), 64'd1);
        check("in_ready8 after reset", 64'(in_ready8), 64'd1);

        // Single-cycle op table on the 64-bit instance.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid64 = 1'b1; ctl64 = vecs[i].op; rs1_64 = vecs[i].a; rs2_64 = vecs[i].b;
            out_ready64 = 1'b1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready64), 64'd1);
            @(posedge clk); #1;
            in_valid64 = 1'b0;
            check($sformatf("v%0d out_valid", i), 64'(out_valid64), 64'd1);
            check($sformatf("v%0d rd", i), rd64, vecs[i].rd);
            check($sformatf("v%0d zero", i), 64'(zero64), 64'(vecs[i].z));
            check($sformatf("v%0d carry", i), 64'(carry64), 64'(vecs[i].c));
            check($sformatf("v%0d overflow", i), 64'(ovf64), 64'(vecs[i].v));
            check($sformatf("v%0d illegal", i), 64'(ill64), 64'(vecs[i].ill));
        end

        // Back-to-back ADDs, one result per cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid64 = 1'b1; ctl64 = C_ADD; out_ready64 = 1'b1;
            rs1_64 = 64'(10 ** k); rs2_64 = 64'(2 * (10 ** k));
            @(posedge clk); #1;
            check($sformatf("b2b%0d out_valid", k), 64'(out_valid64), 64'd1);
            check($sformatf("b2b%0d rd", k), rd64, 64'(3 * (10 ** k)));
        end

        // Consumer stalls: result held, new request ignored.
        @(negedge clk);
        out_ready64 = 1'b0; in_valid64 = 1'b1; ctl64 = C_ADD; rs1_64 = 64'd7; rs2_64 = 64'd7;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d rd", k), rd64, 64'd300);
            check($sformatf("stall%0d out_valid", k), 64'(out_valid64), 64'd1);
            check($sformatf("stall%0d in_ready", k), 64'(in_ready64), 64'd0);
        end
        @(negedge clk);
        in_valid64 = 1'b0; out_ready64 = 1'b1;
        @(posedge clk); #1;
        check("drain out_valid", 64'(out_valid64), 64'd0);
        check("drain in_ready", 64'(in_ready64), 64'd1);

        // Multiply codes rejected when the multiplier is compiled out; also 8-bit ADD edge.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid8n = 1'b1; out_ready8n = 1'b1;
            ctl8n = (k == 0) ? C_MUL : (k == 1) ? C_MULHU : C_ADD;
            rs1_8n = (k == 2) ? 8'h80 : 8'hFF;
            rs2_8n = (k == 2) ? 8'h80 : 8'hFF;
            @(posedge clk); #1;
            in_valid8n = 1'b0;
            check($sformatf("n%0d out_valid", k), 64'(out_valid8n), 64'd1);
            check($sformatf("n%0d rd", k), 64'(rd8n), 64'd0);
            check($sformatf("n%0d zero", k), 64'(zero8n), 64'd1);
            check($sformatf("n%0d illegal", k), 64'(ill8n), (k == 2) ? 64'd0 : 64'd1);
            check($sformatf("n%0d carry", k), 64'(carry8n), (k == 2) ? 64'd1 : 64'd0);
            check($sformatf("n%0d overflow", k), 64'(ovf8n), (k == 2) ? 64'd1 : 64'd0);
        end

        mul8(C_MUL,   8'h03, 8'h05, 8'h0F, 1'b0);
        mul8(C_MUL,   8'h10, 8'h10, 8'h00, 1'b1);
        mul8(C_MULHU, 8'h00, 8'h37, 8'h00, 1'b0);
        mul8(C_MULHU, 8'hFF, 8'hFF, 8'hFE, 1'b1);
        mul8(C_MUL,   8'hFF, 8'hFF, 8'h01, 1'b1);

        // Reset during the multiply: operation abandoned, outputs cleared.
        @(negedge clk);
        in_valid8 = 1'b1; ctl8 = C_MULHU; rs1_8 = 8'hFF; rs2_8 = 8'hFF; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst8_n = 1'b0;
        #1;
        check("midmul reset out_valid", 64'(out_valid8), 64'd0);
        check("midmul reset rd", 64'(rd8), 64'd0);
        check("midmul reset flags", {60'd0, zero8, carry8, ovf8, ill8}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst8_n = 1'b1;
        @(posedge clk); #1;
        check("midmul in_ready after release", 64'(in_ready8), 64'd1);
        check("midmul out_valid after release", 64'(out_valid8), 64'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check("abandoned result never presented", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
